im_ca_fetch: RTL and testbench

- Sequencer that sits directly downstream of the rule-90 cellular-automaton item-memory generator and owns its `Enable_SI` / `Clear_SI` controls.
- Accepts a requested item index over a valid/ready handshake and steps the generator forward from its current state, or clears it and steps again, until it reaches that index.
- Registers the resulting hypervector and presents it, tagged with its index, to the spatial encoder over a second valid/ready handshake.
- The generator and this block share `Clk_CI` and `Reset_RI`, so both return to the seed state together.

---
 rtl/im_ca_fetch_pkg.sv | 23 ++
 rtl/im_gen_rule_90.sv | 25 ++
 rtl/im_ca_fetch.sv | 106 ++++++++++
 tb/tb_im_ca_fetch.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/im_ca_fetch_pkg.sv
// rtl/im_ca_fetch_pkg.sv - shared constants and index clamp for the item-memory fetch slice
`ifndef HV_DIMENSION
`define HV_DIMENSION 32
`endif
`ifndef CELLULAR_AUTOMATON_SEED
`define CELLULAR_AUTOMATON_SEED 32'h8001_0410
`endif
`ifndef NUM_ITEMS
`define NUM_ITEMS 4
`endif

package im_ca_fetch_pkg;

    localparam int HV_DIMENSION = `HV_DIMENSION;
    localparam int NUM_ITEMS_DEFAULT = `NUM_ITEMS;
    localparam logic [HV_DIMENSION-1:0] CA_SEED = `CELLULAR_AUTOMATON_SEED;

    // Out-of-range requests are served as the last item.
    function automatic logic [31:0] clamp_index(input logic [31:0] idx, input logic [31:0] num_items);
        return (idx >= num_items) ? num_items - 32'd1 : idx;
    endfunction

endpackage

// File: rtl/im_gen_rule_90.sv
// rtl/im_gen_rule_90.sv - rule-90 cellular-automaton item-memory generator
module im_gen_rule_90
    import im_ca_fetch_pkg::*;
#(
    parameter int WIDTH = HV_DIMENSION,
    parameter logic [WIDTH-1:0] SEED = CA_SEED
) (
    input  logic             Clk_CI,
    input  logic             Reset_RI,
    input  logic             Enable_SI,
    input  logic             Clear_SI,
    output logic [WIDTH-1:0] CellValueOut_DO
);

    // Each cell becomes the XOR of its cyclic left and right neighbours.
    always_ff @(posedge Clk_CI) begin
        if (Reset_RI || Clear_SI) begin
            CellValueOut_DO <= SEED;
        end else if (Enable_SI) begin
            CellValueOut_DO <= {CellValueOut_DO[0], CellValueOut_DO[WIDTH-1:1]}
                             ^ {CellValueOut_DO[WIDTH-2:0], CellValueOut_DO[WIDTH-1]};
        end
    end

endmodule

// File: rtl/im_ca_fetch.sv
// rtl/im_ca_fetch.sv - sequences the rule-90 generator to a requested item and hands the vector on
module im_ca_fetch
    import im_ca_fetch_pkg::*;
#(
    parameter int WIDTH = HV_DIMENSION,
    parameter int NUM_ITEMS = NUM_ITEMS_DEFAULT,
    parameter int IDX_WIDTH = 2
) (
    input  logic                 Clk_CI,
    input  logic                 Reset_RI,
    input  logic                 ReqValid_SI,
    output logic                 ReqReady_SO,
    input  logic [IDX_WIDTH-1:0] ReqIdx_DI,
    output logic                 GenEnable_SO,
    output logic                 GenClear_SO,
    input  logic [WIDTH-1:0]     GenValue_DI,
    output logic                 HvValid_SO,
    input  logic                 HvReady_SI,
    output logic [WIDTH-1:0]     Hv_DO,
    output logic [IDX_WIDTH-1:0] HvIdx_DO
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CLEAR   = 3'd1,
        STEP    = 3'd2,
        CAPTURE = 3'd3,
        OUT     = 3'd4
    } state_t;

    state_t               state;
    logic [IDX_WIDTH-1:0] Step_S;
    logic [IDX_WIDTH-1:0] Target_S;
    logic [IDX_WIDTH-1:0] req_target;
    logic [IDX_WIDTH-1:0] step_next;

    assign req_target  = IDX_WIDTH'(clamp_index(32'(ReqIdx_DI), NUM_ITEMS));
    assign step_next   = Step_S + IDX_WIDTH'(1);
    assign ReqReady_SO = (state == IDLE) && !Reset_RI;

    // Step_S mirrors the generator: it moves only on the same pulses the generator sees.
    always_ff @(posedge Clk_CI) begin
        if (Reset_RI) begin
            state        <= IDLE;
            Step_S       <= '0;
            Target_S     <= '0;
            GenEnable_SO <= 1'b0;
            GenClear_SO  <= 1'b0;
            HvValid_SO   <= 1'b0;
            Hv_DO        <= '0;
            HvIdx_DO     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ReqValid_SI) begin
                        Target_S <= req_target;
                        if (req_target == Step_S) begin
                            state <= CAPTURE;
                        end else if (req_target > Step_S) begin
                            state        <= STEP;
                            GenEnable_SO <= 1'b1;
                        end else begin
                            state       <= CLEAR;
                            GenClear_SO <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    GenClear_SO <= 1'b0;
                    Step_S      <= '0;
                    if (Target_S == '0) begin
                        state <= CAPTURE;
                    end else begin
                        state        <= STEP;
                        GenEnable_SO <= 1'b1;
                    end
                end
                STEP: begin
                    Step_S <= step_next;
                    if (step_next == Target_S) begin
                        state        <= CAPTURE;
                        GenEnable_SO <= 1'b0;
                    end
                end
                CAPTURE: begin
                    Hv_DO      <= GenValue_DI;
                    HvIdx_DO   <= Target_S;
                    HvValid_SO <= 1'b1;
                    state      <= OUT;
                end
                OUT: begin
                    if (HvReady_SI) begin
                        HvValid_SO <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state        <= IDLE;
                    GenEnable_SO <= 1'b0;
                    GenClear_SO  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_im_ca_fetch.sv
// tb/tb_im_ca_fetch.sv - directed bench for im_ca_fetch driving a real rule-90 generator
module tb_im_ca_fetch;
    import im_ca_fetch_pkg::*;

    localparam int W  = HV_DIMENSION;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [IW-1:0] req_idx = '0;
    logic          gen_enable;
    logic          gen_clear;
    logic [W-1:0]  gen_value;
    logic          hv_valid;
    logic          hv_ready = 1'b0;
    logic [W-1:0]  hv;
    logic [IW-1:0] hv_idx;

    int errors = 0;
    int checks = 0;
    logic [W-1:0] ref_hv [0:3];

    always #5 clk = ~clk;

    im_ca_fetch #(.WIDTH(W), .NUM_ITEMS(4), .IDX_WIDTH(IW)) dut (
        .Clk_CI(clk), .Reset_RI(rst),
        .ReqValid_SI(req_valid), .ReqReady_SO(req_ready), .ReqIdx_DI(req_idx),
        .GenEnable_SO(gen_enable), .GenClear_SO(gen_clear), .GenValue_DI(gen_value),
        .HvValid_SO(hv_valid), .HvReady_SI(hv_ready), .Hv_DO(hv), .HvIdx_DO(hv_idx)
    );

    im_gen_rule_90 #(.WIDTH(W), .SEED(CA_SEED)) gen (
        .Clk_CI(clk), .Reset_RI(rst), .Enable_SI(gen_enable), .Clear_SI(gen_clear),
        .CellValueOut_DO(gen_value)
    );

    function automatic logic [W-1:0] rule90(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[(i + 1) % W] ^ v[(i + W - 1) % W];
        return r;
    endfunction

    // Issues one request and watches the generator controls until HvValid rises.
    task automatic fetch(input logic [IW-1:0] idx, output logic rdy, output int lat,
                         output int n_en, output int n_clr, output int first_en,
                         output int first_clr, output int overlap);
        lat = 99; n_en = 0; n_clr = 0; first_en = -1; first_clr = -1; overlap = 0;
        @(negedge clk);
        rdy = req_ready;
        req_valid = 1'b1;
        req_idx = idx;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (hv_valid) begin
                lat = c;
                break;
            end
            if (gen_enable && gen_clear) overlap++;
            if (gen_enable) begin
                n_en++;
                if (first_en < 0) first_en = c;
            end
            if (gen_clear) begin
                n_clr++;
                if (first_clr < 0) first_clr = c;
            end
        end
    endtask

    task automatic handshake(output logic rdy_after, output logic valid_after);
        hv_ready = 1'b1;
        @(posedge clk);
        #1 hv_ready = 1'b0;
        @(negedge clk);
        rdy_after = req_ready;
        valid_after = hv_valid;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got=%b exp=0", req_ready); end
        checks++; if (hv_valid !== 1'b0) begin errors++; $display("FAIL reset_hv_valid got=%b exp=0", hv_valid); end
        checks++; if (hv !== '0) begin errors++; $display("FAIL reset_hv got=%h exp=0", hv); end
        checks++; if (hv_idx !== '0) begin errors++; $display("FAIL reset_hv_idx got=%0d exp=0", hv_idx); end
        checks++; if ({gen_enable, gen_clear} !== 2'b00) begin errors++; $display("FAIL reset_gen got=%b exp=00", {gen_enable, gen_clear}); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL release_req_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_equal_index();
        logic rdy, ra, va; int lat, ne, nc, fe, fc, ov;
        fetch(3'd0, rdy, lat, ne, nc, fe, fc, ov);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL eq_ready got=%b exp=1", rdy); end
        checks++; if (lat !== 2) begin errors++; $display("FAIL eq_latency got=%0d exp=2", lat); end
        checks++; if (ne + nc !== 0) begin errors++; $display("FAIL eq_pulses got=%0d exp=0", ne + nc); end
        checks++; if (hv !== ref_hv[0]) begin errors++; $display("FAIL eq_hv got=%h exp=%h", hv, ref_hv[0]); end
        checks++; if (hv_idx !== 3'd0) begin errors++; $display("FAIL eq_idx got=%0d exp=0", hv_idx); end
        handshake(ra, va);
        checks++; if ({ra, va} !== 2'b10) begin errors++; $display("FAIL eq_release got=%b exp=10", {ra, va}); end
    endtask

    task automatic test_forward();
        logic rdy, ra, va; int lat, ne, nc, fe, fc, ov;
        fetch(3'd3, rdy, lat, ne, nc, fe, fc, ov);
        checks++; if (lat !== 5) begin errors++; $display("FAIL fwd_latency got=%0d exp=5", lat); end
        checks++; if (ne !== 3) begin errors++; $display("FAIL fwd_enables got=%0d exp=3", ne); end
        checks++; if (nc !== 0) begin errors++; $display("FAIL fwd_clears got=%0d exp=0", nc); end
        checks++; if (hv !== ref_hv[3]) begin errors++; $display("FAIL fwd_hv got=%h exp=%h", hv, ref_hv[3]); end
        checks++; if (hv_idx !== 3'd3) begin errors++; $display("FAIL fwd_idx got=%0d exp=3", hv_idx); end
        handshake(ra, va);
    endtask

    task automatic test_backward();
        logic rdy, ra, va; int lat, ne, nc, fe, fc, ov;
        fetch(3'd1, rdy, lat, ne, nc, fe, fc, ov);
        checks++; if (lat !== 4) begin errors++; $display("FAIL back_latency got=%0d exp=4", lat); end
        checks++; if (nc !== 1 || ne !== 1) begin errors++; $display("FAIL back_pulses got=clr%0d/en%0d exp=clr1/en1", nc, ne); end
        checks++; if (fc !== 1 || fe !== 2) begin errors++; $display("FAIL back_order got=clr@%0d/en@%0d exp=clr@1/en@2", fc, fe); end
        checks++; if (ov !== 0) begin errors++; $display("FAIL back_overlap got=%0d exp=0", ov); end
        checks++; if (hv !== ref_hv[1]) begin errors++; $display("FAIL back_hv got=%h exp=%h", hv, ref_hv[1]); end
        checks++; if (hv_idx !== 3'd1) begin errors++; $display("FAIL back_idx got=%0d exp=1", hv_idx); end
        handshake(ra, va);
    endtask

    task automatic test_backpressure();
        logic rdy, ra, va; int lat, ne, nc, fe, fc, ov;
        fetch(3'd2, rdy, lat, ne, nc, fe, fc, ov);
        checks++; if (lat !== 3 || hv !== ref_hv[2]) begin errors++; $display("FAIL bp_fetch got=lat%0d/%h exp=lat3/%h", lat, hv, ref_hv[2]); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (hv_valid !== 1'b1 || req_ready !== 1'b0 || gen_enable !== 1'b0 || gen_clear !== 1'b0
                || hv !== ref_hv[2] || hv_idx !== 3'd2) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d got=v%b r%b e%b c%b idx%0d hv=%h exp=v1 r0 e0 c0 idx2 hv=%h",
                         c, hv_valid, req_ready, gen_enable, gen_clear, hv_idx, hv, ref_hv[2]);
            end
        end
        handshake(ra, va);
        checks++; if ({ra, va} !== 2'b10) begin errors++; $display("FAIL bp_release got=%b exp=10", {ra, va}); end
    endtask

    task automatic test_reset_mid_step();
        logic rdy, ra, va; int lat, ne, nc, fe, fc, ov; bit seen;
        fetch(3'd0, rdy, lat, ne, nc, fe, fc, ov);
        checks++; if (lat !== 3 || nc !== 1 || ne !== 0) begin errors++; $display("FAIL to_seed got=lat%0d clr%0d en%0d exp=lat3 clr1 en0", lat, nc, ne); end
        handshake(ra, va);
        @(negedge clk);
        req_valid = 1'b1;
        req_idx = 3'd3;
        @(posedge clk);
        #1 req_valid = 1'b0;
        seen = 0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (gen_enable) seen = 1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL mid_step_pulse got=none exp=enable"); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (hv_valid !== 1'b0 || req_ready !== 1'b0 || gen_enable !== 1'b0 || gen_clear !== 1'b0
            || hv !== '0 || hv_idx !== '0) begin
            errors++;
            $display("FAIL mid_reset got=v%b r%b e%b c%b idx%0d hv=%h exp=all zero",
                     hv_valid, req_ready, gen_enable, gen_clear, hv_idx, hv);
        end
        rst = 1'b0;
        fetch(3'd2, rdy, lat, ne, nc, fe, fc, ov);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL post_reset_ready got=%b exp=1", rdy); end
        checks++; if (ne !== 2 || nc !== 0) begin errors++; $display("FAIL post_reset_pulses got=en%0d/clr%0d exp=en2/clr0", ne, nc); end
        checks++; if (lat !== 4) begin errors++; $display("FAIL post_reset_latency got=%0d exp=4", lat); end
        checks++; if (hv !== ref_hv[2]) begin errors++; $display("FAIL post_reset_hv got=%h exp=%h", hv, ref_hv[2]); end
        handshake(ra, va);
    endtask

    task automatic test_clamp();
        logic rdy, ra, va; int lat, ne, nc, fe, fc, ov;
        fetch(3'd7, rdy, lat, ne, nc, fe, fc, ov);
        checks++; if (hv_idx !== 3'd3) begin errors++; $display("FAIL clamp_idx got=%0d exp=3", hv_idx); end
        checks++; if (hv !== ref_hv[3]) begin errors++; $display("FAIL clamp_hv got=%h exp=%h", hv, ref_hv[3]); end
        checks++; if (lat !== 3 || ne !== 1 || nc !== 0) begin errors++; $display("FAIL clamp_path got=lat%0d en%0d clr%0d exp=lat3 en1 clr0", lat, ne, nc); end
        handshake(ra, va);
        checks++; if ({ra, va} !== 2'b10) begin errors++; $display("FAIL clamp_release got=%b exp=10", {ra, va}); end
    endtask

    initial begin
        ref_hv[0] = CA_SEED;
        for (int i = 1; i < 4; i++) ref_hv[i] = rule90(ref_hv[i-1]);
        test_reset();
        test_equal_index();
        test_forward();
        test_backward();
        test_backpressure();
        test_reset_mid_step();
        test_clamp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
